// File: rtl/mesh_term_tx.sv
// Terminal-side packet source for the mesh router: validates local writes, packs them into
// router words, buffers them in a FWFT FIFO and tracks sent/drop counts and router stalls.
module mesh_term_tx #(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLUMNS     = 4,
  parameter int unsigned PAKG_SIZE   = 32,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned MY_ROW      = 0,
  parameter int unsigned MY_COL      = 1,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [3:0]                    wr_row,
  input  logic [3:0]                    wr_col,
  input  logic                          wr_mode,
  input  logic [PAKG_SIZE-18:0]         wr_payload,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          pndng_i_in,
  output logic [PAKG_SIZE-1:0]          data_out_i_in,
  input  logic                          popin,
  output logic [15:0]                   sent_cnt,
  output logic [15:0]                   drop_cnt,
  output logic                          stall
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(STALL_LIMIT + 1);

  localparam logic [3:0]    RowMax  = 4'(ROWS);
  localparam logic [3:0]    ColMax  = 4'(COLUMNS);
  localparam logic [3:0]    RowEdge = 4'(ROWS + 1);
  localparam logic [3:0]    ColEdge = 4'(COLUMNS + 1);
  localparam logic [3:0]    SelfRow = 4'(MY_ROW);
  localparam logic [3:0]    SelfCol = 4'(MY_COL);
  localparam logic [CW-1:0] Depth   = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] Limit   = TW'(STALL_LIMIT);

  typedef enum logic [0:0] {StIdle, StWait} stall_state_e;

  logic [PAKG_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d, remain;
  logic [PAKG_SIZE-1:0] data_q, data_d, wr_word;
  logic [15:0]          sent_q, drop_q;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 stall_q, stall_d;
  stall_state_e         state_q, state_d;

  logic row_side, col_side, self_hit, push, pop, reject;

  // Legal targets are the off-mesh ring cells: north/south or west/east terminals.
  assign row_side = (wr_row == 4'd0 || wr_row == RowEdge) && wr_col >= 4'd1 && wr_col <= ColMax;
  assign col_side = (wr_col == 4'd0 || wr_col == ColEdge) && wr_row >= 4'd1 && wr_row <= RowMax;
  assign self_hit = (wr_row == SelfRow) && (wr_col == SelfCol);

  assign pop     = popin && (count_q != '0);
  assign push    = wr_en && (row_side || col_side) && !self_hit && (count_q != Depth || popin);
  assign reject  = wr_en && !push;
  assign wr_word = {8'h00, wr_row, wr_col, wr_mode, wr_payload};

  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign remain   = count_q - CW'(pop);
  assign count_d  = remain + CW'(push);

  // Head register tracks the post-update head; it holds its value once the FIFO drains.
  always_comb begin
    data_d = data_q;
    if (count_d != '0) begin
      data_d = (remain == '0) ? wr_word : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      sent_q   <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      if (pop) sent_q <= sent_q + 16'd1;
      if (reject && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  // Stall detector: state register, next-state logic, timer/flag logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (!popin && count_q != '0) begin
      state_d = StWait;
    end
  end

  always_comb begin
    timer_d = '0;
    if (state_d == StWait) begin
      timer_d = (timer_q == Limit) ? timer_q : timer_q + TW'(1);
    end
    stall_d = stall_q || (timer_d == Limit);
  end

  assign full          = (count_q == Depth);
  assign count         = count_q;
  assign pndng_i_in    = (count_q != '0);
  assign data_out_i_in = data_q;
  assign sent_cnt      = sent_q;
  assign drop_cnt      = drop_q;
  assign stall         = stall_q;

endmodule

// File: tb/tb_mesh_term_tx.sv
// Randomized bench for mesh_term_tx against a queue-based reference model, plus directed
// scenarios for fill/drop, self/illegal targets, pointer wrap and the stall flag.
module tb_mesh_term_tx;

  localparam int unsigned ROWS = 4, COLUMNS = 4, PAKG_SIZE = 32, FIFO_DEPTH = 16;
  localparam int unsigned MY_ROW = 0, MY_COL = 1, STALL_LIMIT = 64;
  localparam int unsigned PW = PAKG_SIZE - 17;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 wr_en = 1'b0;
  logic [3:0]           wr_row = '0, wr_col = '0;
  logic                 wr_mode = 1'b0;
  logic [PW-1:0]        wr_payload = '0;
  logic                 full;
  logic [4:0]           count;
  logic                 pndng_i_in;
  logic [PAKG_SIZE-1:0] data_out_i_in;
  logic                 popin = 1'b0;
  logic [15:0]          sent_cnt, drop_cnt;
  logic                 stall;

  mesh_term_tx #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .PAKG_SIZE(PAKG_SIZE), .FIFO_DEPTH(FIFO_DEPTH),
    .MY_ROW(MY_ROW), .MY_COL(MY_COL), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_mode(wr_mode), .wr_payload(wr_payload), .full(full), .count(count),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
    .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [PAKG_SIZE-1:0] q[$];
  logic [PAKG_SIZE-1:0] m_head = '0;
  logic [15:0]          m_sent = '0, m_drop = '0;
  int                   m_wait = 0;
  logic                 m_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit target_ok(input logic [3:0] r, input logic [3:0] c);
    int ri = int'(r), ci = int'(c);
    bit on_ring = ((ri == 0 || ri == ROWS + 1) && ci >= 1 && ci <= COLUMNS) ||
                  ((ci == 0 || ci == COLUMNS + 1) && ri >= 1 && ri <= ROWS);
    return on_ring && !(ri == MY_ROW && ci == MY_COL);
  endfunction

  task automatic model_edge(input logic we, input logic [3:0] r, input logic [3:0] c,
                            input logic m, input logic [PW-1:0] p, input logic pop,
                            input logic rst);
    bit pend, acc;
    if (rst) begin
      q.delete();
      m_head = '0; m_sent = '0; m_drop = '0; m_wait = 0; m_stall = 1'b0;
      return;
    end
    pend = (q.size() != 0);
    acc  = we && target_ok(r, c) && (q.size() < FIFO_DEPTH || pop);
    if (we && !acc && m_drop != 16'hFFFF) m_drop++;
    if (pop && pend) begin
      void'(q.pop_front());
      m_sent++;
    end
    if (acc) q.push_back({8'h00, r, c, m, p});
    if (pop) m_wait = 0;
    else if (pend) m_wait++;
    if (m_wait >= STALL_LIMIT) m_stall = 1'b1;
    if (q.size() != 0) m_head = q[0];
  endtask

  task automatic step(input logic we, input logic [3:0] r, input logic [3:0] c,
                      input logic m, input logic [PW-1:0] p, input logic pop,
                      input logic rst);
    wr_en = we; wr_row = r; wr_col = c; wr_mode = m; wr_payload = p; popin = pop; reset = rst;
    @(posedge clk);
    model_edge(we, r, c, m, p, pop, rst);
    #1;
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == FIFO_DEPTH));
    check("pndng", 32'(pndng_i_in), 32'(q.size() != 0));
    check("data_out", data_out_i_in, m_head);
    check("sent_cnt", 32'(sent_cnt), 32'(m_sent));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("stall", 32'(stall), 32'(m_stall));
  endtask

  task automatic do_reset();
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic pop);
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, pop, 1'b0);
  endtask

  task automatic rand_target(output logic [3:0] r, output logic [3:0] c);
    int sel = $urandom_range(0, 7);
    int k = $urandom_range(1, 4);
    unique case (sel)
      0: begin r = 4'd0; c = 4'(k); end
      1: begin r = 4'd5; c = 4'(k); end
      2: begin r = 4'(k); c = 4'd0; end
      3: begin r = 4'(k); c = 4'd5; end
      4: begin r = 4'd0; c = 4'd1; end
      5: begin r = 4'(k); c = 4'($urandom_range(1, 4)); end
      default: begin r = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15)); end
    endcase
  endtask

  initial begin
    logic [3:0] r, c;
    int pop_pct;

    // Single packet round trip
    do_reset();
    step(1'b1, 4'd0, 4'd2, 1'b0, 15'h1234, 1'b0, 1'b0);
    check("tp1_data", data_out_i_in, 32'h0002_1234);
    check("tp1_count", 32'(count), 32'd1);
    idle(1'b1);
    check("tp1_pndng", 32'(pndng_i_in), 32'd0);
    check("tp1_sent", 32'(sent_cnt), 32'd1);

    // Fill, overflow drop, full write with pop, drain in order
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 4'd5, 4'(1 + i % 4), i[0], 15'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    step(1'b1, 4'd0, 4'd3, 1'b0, 15'h7ABC, 1'b0, 1'b0);
    check("ovf_drop", 32'(drop_cnt), 32'd1);
    step(1'b1, 4'd0, 4'd3, 1'b1, 15'h7ABC, 1'b1, 1'b0);
    check("fullpop_count", 32'(count), 32'd16);
    check("fullpop_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 17; i++) idle(1'b1);

    // Interior and self-addressed targets
    do_reset();
    step(1'b1, 4'd2, 4'd2, 1'b0, 15'h1111, 1'b0, 1'b0);
    step(1'b1, 4'd0, 4'd1, 1'b0, 15'h2222, 1'b0, 1'b0);
    check("rej_drop", 32'(drop_cnt), 32'd2);
    check("rej_pndng", 32'(pndng_i_in), 32'd0);

    // Streaming write+pop across pointer wrap
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 4'(1 + i % 4), 4'd0, 1'b0, 15'(i * 7), 1'b1, 1'b0);
    check("stream_count", 32'(count), 32'd1);
    check("stream_sent", 32'(sent_cnt), 32'd39);
    check("stream_head", data_out_i_in, {8'h00, 4'd4, 4'd0, 1'b0, 15'(39 * 7)});

    // Stall detector and reset recovery
    do_reset();
    step(1'b1, 4'd3, 4'd5, 1'b1, 15'h0F0F, 1'b0, 1'b0);
    for (int i = 0; i < 63; i++) idle(1'b0);
    check("stall_pre", 32'(stall), 32'd0);
    idle(1'b0);
    check("stall_set", 32'(stall), 32'd1);
    idle(1'b1);
    check("stall_sticky", 32'(stall), 32'd1);
    do_reset();
    check("stall_rst", 32'(stall), 32'd0);
    check("rst_count", 32'(count), 32'd0);

    // Pop while empty
    idle(1'b1);
    check("empty_pop_sent", 32'(sent_cnt), 32'd0);
    check("empty_pop_count", 32'(count), 32'd0);

    // Randomized traffic with varying pop pressure
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      pop_pct = ((i / 150) % 3 == 0) ? 10 : (((i / 150) % 3 == 1) ? 50 : 90);
      rand_target(r, c);
      step(1'($urandom_range(0, 99) < 70), r, c, 1'($urandom_range(0, 1)),
           PW'($urandom), 1'($urandom_range(0, 99) < pop_pct),
           1'($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
